alu_iterative_mul: RTL and testbench
====================================

Name: alu_iterative_mul

Overview:
- EX-stage ALU that directly consumes the 3-bit ALU control code produced by the ALU control decoder.
- Seven operations complete combinationally in one cycle.
- mul runs on an iterative shift-add multiplier. It raises a stall request to the hazard unit until the product is ready, which freezes PC, IF/ID and ID/EX.
- Result and zero flag feed the EX/MEM pipeline register.

Parameters:
WIDTH, 32, operand/result width; also the number of multiplier iterations.

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  reset, synchronous, active-low
valid_i  input  1  ID/EX holds a real instruction (0 = bubble)
ALUCtrl_i  input  3  operation code from ALU control
data1_i  input  WIDTH  operand 1 (rs1, post-forwarding)
data2_i  input  WIDTH  operand 2 (rs2 or immediate, post-forwarding)
result_o  output  WIDTH  ALU result to EX/MEM
zero_o  output  1  result_o == 0
stall_o  output  1  hold upstream pipeline (to hazard unit)

Behaviour:
- Op codes:
  - 000 and: data1 & data2.
  - 001 xor: data1 ^ data2.
  - 010 sll: data1 << data2[4:0].
  - 011 add, 110 addi: data1 + data2, wrap mod 2^WIDTH.
  - 100 sub: data1 - data2, wrap mod 2^WIDTH.
  - 101 mul: low WIDTH bits of data1*data2.
  - 111 srai: data1 >>> data2[4:0], sign-filled.
- Only data2[4:0] is used as a shift amount. Upper bits of data2 are ignored for shifts.
- FSM states: IDLE, BUSY, DONE. Registers: acc (WIDTH), mcand (WIDTH), mplier (WIDTH), cnt (log2 WIDTH + 1 bits).
- IDLE:
  - Non-mul or valid_i=0: result_o combinational from inputs, stall_o=0, state stays IDLE.
  - valid_i=1 and ALUCtrl_i=101: stall_o=1 combinationally that cycle, result_o=0. At the clock edge: acc<=0, mcand<=data1_i, mplier<=data2_i, cnt<=0, go to BUSY.
- BUSY, one iteration per cycle:
  - If mplier[0], acc<=acc+mcand.
  - mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge, go to DONE.
  - stall_o=1 and result_o=0 throughout.
  - Inputs are ignored while BUSY; they are held stable by the stall.
- DONE:
  - result_o=acc, zero_o=(acc==0), stall_o=0. The pipeline advances this cycle, consuming the product.
  - Next state is IDLE unconditionally, even if inputs still show mul. The instruction has left ID/EX at this edge, so the mul is not re-executed.
- Mul latency:
  - Accepted at cycle T, BUSY for T+1..T+WIDTH, DONE at T+WIDTH+1.
  - WIDTH+1 stall cycles; the mul occupies EX for WIDTH+2 cycles.
- Back-to-back mul: the second mul arrives in IDLE on the cycle after DONE and starts normally. There are no lost or duplicated products.
- valid_i=0 with ALUCtrl_i=101 (bubble): no multiplication starts, stall_o=0, result_o = combinational value (don't care downstream).
- Undefined ALUCtrl_i is not possible (3 bits fully decoded).
- Reset:
  - While rst_i=0 at the edge: state<=IDLE, acc/mcand/mplier/cnt<=0.
  - While rst_i=0: stall_o=0 and result_o=0.
  - Reset during BUSY aborts the multiply with no output.
- zero_o is always derived from result_o.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles while driving mul, valid_i=1 -> stall_o=0, result_o=0. After release, IDLE starts a mul.
- Single-cycle ops with data1=0xF0F0_1234, data2=0x0000_0004:
  - and -> 0x0000_0004.
  - xor -> 0xF0F0_1230.
  - sll -> 0x0F01_2340.
  - add -> 0xF0F0_1238.
  - sub -> 0xF0F0_1230.
  - srai -> 0xFF0F_0123.
  - stall_o=0 throughout; zero_o=1 for sub of equal operands 5-5.
- mul 7 x 6, valid_i=1 held at cycle T:
  - stall_o=1 for cycles T..T+32.
  - At T+33: result_o=42, stall_o=0.
  - At T+34: state is IDLE.
- Overflow and sign:
  - mul 0xFFFF_FFFF x 0xFFFF_FFFF -> 0x0000_0001.
  - mul 0x8000_0000 x 2 -> 0x0000_0000 with zero_o=1 in DONE.
  - mul (-3) x 5 -> 0xFFFF_FFF1.
- Back-to-back: mul 3x4 then mul 5x5 then add 1+1 -> results 12, 25, 2. Exactly 33 stall cycles per mul and none for the add.
- Abort: assert rst_i=0 at BUSY cycle 10 of a mul -> stall_o=0 next cycle, no DONE. A fresh mul 2x9 then yields 18.

Source files
------------

// File: rtl/alu_iterative_mul_if.sv
// Operand and control bundle between ID/EX and the EX-stage ALU, and the
// result, zero flag and stall request it returns.
interface alu_iterative_mul_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid_i;
    logic [2:0]       ALUCtrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             stall_o;

    modport master (
        output valid_i, ALUCtrl_i, data1_i, data2_i,
        input  result_o, zero_o, stall_o
    );

    modport slave (
        input  valid_i, ALUCtrl_i, data1_i, data2_i,
        output result_o, zero_o, stall_o
    );
endinterface

// File: rtl/alu_iterative_mul.sv
// EX-stage ALU: seven single-cycle ops plus a shift-add multiplier that
// holds the pipeline through a stall request until the product is ready.
module alu_iterative_mul #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    alu_iterative_mul_if.slave   bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] comb_res;
    logic [WIDTH-1:0] result;
    logic             stall;
    logic [4:0]       shamt;

    assign shamt = bus.data2_i[4:0];

    always_comb begin
        comb_res = '0;
        case (bus.ALUCtrl_i)
            3'b000:  comb_res = bus.data1_i & bus.data2_i;
            3'b001:  comb_res = bus.data1_i ^ bus.data2_i;
            3'b010:  comb_res = bus.data1_i << shamt;
            3'b011:  comb_res = bus.data1_i + bus.data2_i;
            3'b100:  comb_res = bus.data1_i - bus.data2_i;
            3'b101:  comb_res = '0;
            3'b110:  comb_res = bus.data1_i + bus.data2_i;
            3'b111:  comb_res = WIDTH'($signed(bus.data1_i) >>> shamt);
            default: comb_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result   = comb_res;
        stall    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.valid_i && bus.ALUCtrl_i == 3'b101) begin
                    stall    = 1'b1;
                    result   = '0;
                    acc_d    = '0;
                    mcand_d  = bus.data1_i;
                    mplier_d = bus.data2_i;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                stall    = 1'b1;
                result   = '0;
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
            end
            DONE: begin
                // The mul leaves ID/EX on this edge, so never restart from here.
                result  = acc_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!rst_i) begin
            stall  = 1'b0;
            result = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.result_o = result;
    assign bus.zero_o   = (result == '0);
    assign bus.stall_o  = stall;
endmodule

// File: tb/tb_alu_iterative_mul.sv
// Directed checks of the EX-stage ALU: single-cycle ops, multiply latency,
// overflow, back-to-back multiplies and reset abort.
module tb_alu_iterative_mul;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    alu_iterative_mul_if #(.WIDTH(32)) bus ();

    alu_iterative_mul #(.WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.valid_i   = v;
        bus.ALUCtrl_i = op;
        bus.data1_i   = a;
        bus.data2_i   = b;
    endtask

    task automatic op_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
        drive(1'b1, op, a, b);
        #1;
        check({tag, "_res"}, bus.result_o, exp);
        check({tag, "_stall"}, 32'(bus.stall_o), 32'd0);
    endtask

    // Drives a mul, counts stall cycles and checks the product in DONE,
    // then steps past DONE so the caller drives the next instruction.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        int stalls;
        drive(1'b1, 3'b101, a, b);
        #1;
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.stall_o) break;
            stalls++;
            tick();
        end
        check({tag, "_stalls"}, 32'(stalls), 32'd33);
        check({tag, "_res"}, bus.result_o, exp);
        check({tag, "_zero"}, 32'(bus.zero_o), 32'(exp == 32'd0));
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        drive(1'b1, 3'b101, 32'd7, 32'd6);
        #1;
        check("rst_stall", 32'(bus.stall_o), 32'd0);
        check("rst_res", bus.result_o, 32'd0);
        tick();
        tick();
        check("rst_stall2", 32'(bus.stall_o), 32'd0);
        rst_n = 1'b1;

        // Inputs still show mul 7x6, so IDLE starts it right after release.
        run_mul("mul7x6", 32'd7, 32'd6, 32'd42);
        op_check("idle_add", 3'b011, 32'd1, 32'd1, 32'd2);
        tick();

        op_check("and",  3'b000, 32'hF0F0_1234, 32'h0000_0004, 32'h0000_0004);
        op_check("xor",  3'b001, 32'hF0F0_1234, 32'h0000_0004, 32'hF0F0_1230);
        op_check("sll",  3'b010, 32'hF0F0_1234, 32'h0000_0004, 32'h0F01_2340);
        op_check("add",  3'b011, 32'hF0F0_1234, 32'h0000_0004, 32'hF0F0_1238);
        op_check("addi", 3'b110, 32'hF0F0_1234, 32'h0000_0004, 32'hF0F0_1238);
        op_check("sub",  3'b100, 32'hF0F0_1234, 32'h0000_0004, 32'hF0F0_1230);
        op_check("srai", 3'b111, 32'hF0F0_1234, 32'h0000_0004, 32'hFF0F_0123);
        op_check("sll_hi", 3'b010, 32'h0000_0001, 32'hFFFF_FFE3, 32'h0000_0008);
        op_check("sub_eq", 3'b100, 32'd5, 32'd5, 32'd0);
        check("sub_eq_zero", 32'(bus.zero_o), 32'd1);
        tick();

        drive(1'b0, 3'b101, 32'd3, 32'd3);
        #1;
        check("bubble_stall", 32'(bus.stall_o), 32'd0);
        tick();
        check("bubble_stall2", 32'(bus.stall_o), 32'd0);

        run_mul("mul_ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_mul("mul_ovf", 32'h8000_0000, 32'd2, 32'h0000_0000);
        run_mul("mul_neg", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);

        run_mul("b2b_a", 32'd3, 32'd4, 32'd12);
        run_mul("b2b_b", 32'd5, 32'd5, 32'd25);
        op_check("b2b_add", 3'b011, 32'd1, 32'd1, 32'd2);
        tick();

        // Abort: reset asserted during BUSY cycle 10.
        drive(1'b1, 3'b101, 32'd100, 32'd100);
        #1;
        for (int i = 0; i < 10; i++) tick();
        check("abort_busy", 32'(bus.stall_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_rst_stall", 32'(bus.stall_o), 32'd0);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        #1;
        check("abort_stall", 32'(bus.stall_o), 32'd0);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.stall_o || bus.result_o != 32'd0) break;
        end
        check("abort_nodone_stall", 32'(bus.stall_o), 32'd0);
        check("abort_nodone_res", bus.result_o, 32'd0);
        run_mul("mul2x9", 32'd2, 32'd9, 32'd18);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
